dmem_lmsm_ctrl: RTL and testbench

Sequencer and arbiter in front of the data memory for load-multiple (LM) and store-multiple (SM) instructions. When idle, it passes the pipeline memory-stage single access straight through to the data memory. On an LM/SM start, it takes ownership of the memory port and stalls the pipeline. It then issues one memory word access per cycle for each set bit of an 8-bit register mask, moving data between consecutive memory words and the register file.

---
 rtl/dmem_lmsm_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_lmsm_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lmsm_ctrl.sv
// rtl/dmem_lmsm_ctrl.sv - LM/SM sequencer and data-memory port arbiter
module dmem_lmsm_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int MASK_W = 8,
   parameter int RIDX_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              op_sm,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [MASK_W-1:0] reg_mask,
   output logic              busy,
   output logic              stall,
   output logic              done,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic              pipe_w,
   input  logic [DATA_W-1:0] pipe_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_w,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [RIDX_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [RIDX_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [MASK_W-1:0] r_rem_mask;
   logic [ADDR_W-1:0] r_offset;
   logic [ADDR_W-1:0] r_base;
   logic              r_op;

   logic [RIDX_W-1:0] w_idx;
   logic [MASK_W-1:0] w_next_mask;
   logic [ADDR_W-1:0] w_xfer_addr;

   // Lowest set bit of the remaining mask wins; address wraps naturally
   always_comb begin
      w_idx = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (r_rem_mask[i]) begin
            w_idx = RIDX_W'(i);
         end
      end
      w_next_mask = r_rem_mask & ~(MASK_W'(1) << w_idx);
      w_xfer_addr = r_base + r_offset;
   end

   // Sequencer state and captured operands
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_rem_mask <= '0;
         r_offset   <= '0;
         r_base     <= '0;
         r_op       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op       <= op_sm;
                  r_base     <= base_addr;
                  r_rem_mask <= reg_mask;
                  r_offset   <= '0;
                  r_state    <= (reg_mask != '0) ? S_XFER : S_DONE;
               end
            end
            S_XFER: begin
               r_rem_mask <= w_next_mask;
               r_offset   <= r_offset + ADDR_W'(1);
               if (w_next_mask == '0) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Port muxing; reset_n gates the outputs so a held reset silences
   // the memory write strobe without waiting for a clock
   always_comb begin
      mem_addr  = pipe_addr;
      mem_w     = 1'b0;
      mem_wdata = '0;
      rf_raddr  = '0;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      busy      = 1'b0;
      done      = 1'b0;
      if (reset_n) begin
         case (r_state)
            S_IDLE: begin
               mem_w     = pipe_w;
               mem_wdata = pipe_wdata;
            end
            S_XFER: begin
               busy     = 1'b1;
               mem_addr = w_xfer_addr;
               if (r_op) begin
                  rf_raddr  = w_idx;
                  mem_w     = 1'b1;
                  mem_wdata = rf_rdata;
               end else begin
                  rf_we    = 1'b1;
                  rf_waddr = w_idx;
                  rf_wdata = mem_rdata;
               end
            end
            S_DONE: begin
               busy     = 1'b1;
               done     = 1'b1;
               mem_addr = w_xfer_addr;
            end
            default: begin
               busy = 1'b0;
            end
         endcase
      end
   end

   assign stall = busy;

endmodule

// File: tb/tb_dmem_lmsm_ctrl.sv
// tb/tb_dmem_lmsm_ctrl.sv - randomized self-checking bench for dmem_lmsm_ctrl
module tb_dmem_lmsm_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        op_sm;
   logic [15:0] base_addr;
   logic [7:0]  reg_mask;
   logic        busy;
   logic        stall;
   logic        done;
   logic [15:0] pipe_addr;
   logic        pipe_w;
   logic [15:0] pipe_wdata;
   logic [15:0] mem_addr;
   logic        mem_w;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic [2:0]  rf_raddr;
   logic [15:0] rf_rdata;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [15:0] dmem    [0:65535];
   logic [15:0] exp_mem [0:65535];
   logic [15:0] rf      [0:7];
   logic [15:0] rf_img  [0:7];
   logic [15:0] exp_rf  [0:7];
   logic        rf_load = 1'b0;

   always #5 clk = ~clk;

   dmem_lmsm_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op_sm(op_sm),
      .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .stall(stall),
      .done(done), .pipe_addr(pipe_addr), .pipe_w(pipe_w), .pipe_wdata(pipe_wdata),
      .mem_addr(mem_addr), .mem_w(mem_w), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata)
   );

   // Data memory: writes on the falling edge, combinational read
   always @(negedge clk) if (mem_w) dmem[mem_addr] <= mem_wdata;
   assign mem_rdata = dmem[mem_addr];

   // Register file: writes on the rising edge, bulk image load for setup
   always @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 8; i++) rf[i] <= rf_img[i];
      end else if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end
   assign rf_rdata = rf[rf_raddr];

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single pipeline write through the idle passthrough
   task automatic idle_write(input logic [15:0] a, input logic [15:0] d);
      start = 1'b0; pipe_addr = a; pipe_w = 1'b1; pipe_wdata = d;
      #1;
      check("pass_addr", 32'(mem_addr), 32'(a));
      check("pass_w", 32'(mem_w), 32'd1);
      check("pass_wdata", 32'(mem_wdata), 32'(d));
      check("pass_busy", 32'(busy), 32'd0);
      exp_mem[a] = d;
      tick();
      pipe_w = 1'b0;
   endtask

   task automatic load_rf();
      for (int i = 0; i < 8; i++) begin
         rf_img[i] = 16'($urandom);
         exp_rf[i] = rf_img[i];
      end
      rf_load = 1'b1;
      tick();
      rf_load = 1'b0;
   endtask

   // One full LM/SM operation with distractor inputs while busy
   task automatic run_op(input bit op, input logic [15:0] base, input logic [7:0] mask);
      int idxs[$];
      int done_before;
      logic [15:0] a;
      for (int i = 0; i < 8; i++) if (mask[i]) idxs.push_back(i);
      done_before = done_cnt;
      start = 1'b1; op_sm = op; base_addr = base; reg_mask = mask;
      pipe_addr = 16'($urandom); pipe_w = 1'b0;
      #1;
      check("start_busy", 32'(busy), 32'd0);
      check("start_pass_addr", 32'(mem_addr), 32'(pipe_addr));
      tick();
      for (int k = 0; k < idxs.size(); k++) begin
         start = 1'($urandom); op_sm = 1'($urandom); base_addr = 16'($urandom);
         reg_mask = 8'($urandom); pipe_addr = 16'($urandom); pipe_w = 1'b1;
         pipe_wdata = 16'($urandom);
         #1;
         a = base + 16'(k);
         check("xfer_busy", 32'(busy), 32'd1);
         check("xfer_stall", 32'(stall), 32'd1);
         check("xfer_done", 32'(done), 32'd0);
         check("xfer_addr", 32'(mem_addr), 32'(a));
         check("xfer_mem_w", 32'(mem_w), 32'(op));
         check("xfer_rf_we", 32'(rf_we), 32'(!op));
         if (op) begin
            check("sm_raddr", 32'(rf_raddr), 32'(idxs[k]));
            check("sm_wdata", 32'(mem_wdata), 32'(exp_rf[idxs[k]]));
            exp_mem[a] = exp_rf[idxs[k]];
         end else begin
            check("lm_waddr", 32'(rf_waddr), 32'(idxs[k]));
            check("lm_wdata", 32'(rf_wdata), 32'(exp_mem[a]));
            exp_rf[idxs[k]] = exp_mem[a];
         end
         tick();
      end
      start = 1'($urandom); pipe_w = 1'b1;
      #1;
      check("done_busy", 32'(busy), 32'd1);
      check("done_pulse", 32'(done), 32'd1);
      check("done_mem_w", 32'(mem_w), 32'd0);
      check("done_rf_we", 32'(rf_we), 32'd0);
      tick();
      start = 1'b0; pipe_w = 1'b0;
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("done_count", 32'(done_cnt), 32'(done_before + 1));
      for (int k = 0; k < idxs.size(); k++) begin
         a = base + 16'(k);
         if (op) check("mem_img", 32'(dmem[a]), 32'(exp_mem[a]));
         else    check("rf_img", 32'(rf[idxs[k]]), 32'(exp_rf[idxs[k]]));
      end
   endtask

   initial begin
      logic [15:0] rb;
      logic [7:0]  rm;
      bit          rop;
      int          d0;
      reset_n = 1'b0; start = 1'b0; op_sm = 1'b0; base_addr = '0; reg_mask = '0;
      pipe_addr = 16'h1234; pipe_w = 1'b1; pipe_wdata = 16'h5555;
      #3;
      check("rst_mem_w", 32'(mem_w), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'h1234);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_rf_raddr", 32'(rf_raddr), 32'd0);
      check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      check("rst_rf_wdata", 32'(rf_wdata), 32'd0);
      pipe_w = 1'b0;
      #10;
      reset_n = 1'b1;
      tick();

      // SM of R0/R2/R5/R7 to 0x10..0x13
      load_rf();
      rf_img[0] = 16'hA000; rf_img[2] = 16'hA002; rf_img[5] = 16'hA005; rf_img[7] = 16'hA007;
      for (int i = 0; i < 8; i++) exp_rf[i] = rf_img[i];
      rf_load = 1'b1; tick(); rf_load = 1'b0;
      run_op(1'b1, 16'h0010, 8'b1010_0101);
      check("t1_m10", 32'(dmem[16'h0010]), 32'hA000);
      check("t1_m11", 32'(dmem[16'h0011]), 32'hA002);
      check("t1_m12", 32'(dmem[16'h0012]), 32'hA005);
      check("t1_m13", 32'(dmem[16'h0013]), 32'hA007);

      // LM of two words into R1/R7
      load_rf();
      idle_write(16'h0020, 16'h1234);
      idle_write(16'h0021, 16'hBEEF);
      run_op(1'b0, 16'h0020, 8'b1000_0010);
      check("t2_r1", 32'(rf[1]), 32'h1234);
      check("t2_r7", 32'(rf[7]), 32'hBEEF);

      // Zero mask goes straight to DONE
      run_op(1'b1, 16'h4000, 8'h00);
      run_op(1'b0, 16'h4000, 8'h00);

      // Address wrap across 0xFFFF
      load_rf();
      run_op(1'b1, 16'hFFFE, 8'hFF);
      check("t4_m0000", 32'(dmem[16'h0000]), 32'(exp_rf[2]));

      // Plain passthrough write
      idle_write(16'h0005, 16'h0077);
      check("t5_m5", 32'(dmem[16'h0005]), 32'h0077);

      // Reset during the second XFER cycle of an 8-word SM
      load_rf();
      idle_write(16'h0301, 16'hDEAD);
      d0 = done_cnt;
      start = 1'b1; op_sm = 1'b1; base_addr = 16'h0300; reg_mask = 8'hFF; pipe_w = 1'b0;
      #1;
      tick();
      start = 1'b0;
      #1;
      check("t6_first_w", 32'(mem_w), 32'd1);
      tick();
      #1;
      pipe_addr = 16'h0400; pipe_w = 1'b1;
      reset_n = 1'b0;
      #1;
      check("t6_rst_mem_w", 32'(mem_w), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_addr", 32'(mem_addr), 32'h0400);
      tick();
      tick();
      pipe_w = 1'b0;
      reset_n = 1'b1;
      tick();
      #1;
      check("t6_idle", 32'(busy), 32'd0);
      check("t6_m300", 32'(dmem[16'h0300]), 32'(exp_rf[0]));
      check("t6_m301", 32'(dmem[16'h0301]), 32'hDEAD);
      check("t6_no_done", 32'(done_cnt), 32'(d0));

      // Randomized operations
      for (int n = 0; n < 8; n++) begin
         rop = 1'($urandom);
         rb  = 16'($urandom);
         rm  = 8'($urandom);
         load_rf();
         if (!rop) begin
            for (int k = 0; k < $countones(rm); k++) idle_write(rb + 16'(k), 16'($urandom));
         end
         run_op(rop, rb, rm);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
